// File: rtl/dff_load_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | dff_arb_pkg : shared types and helpers for dff_load_arbiter          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package dff_arb_pkg;

  localparam int GAP_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dff_load_arbiter_if.sv
// +----------------------------------------------------------------------+
// | dff_load_arbiter_if : requester-side bus of the load arbiter         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface dff_load_arbiter_if
  import dff_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) ();

  localparam int IDX_W = clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic                  clr;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic [IDX_W-1:0]      owner;

  modport master (
    output req, wr_data, clr,
    input  gnt, q, q_valid, owner
  );

  modport slave (
    input  req, wr_data, clr,
    output gnt, q, q_valid, owner
  );

endinterface

`default_nettype wire

// File: rtl/dff_load_arbiter_rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick : first set request at or above ptr, wrapping modulo NREQ    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  int w_j;

  always_comb begin
    any = 1'b0;
    idx = '0;
    w_j = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!any && req[w_j]) begin
        any = 1'b1;
        idx = IDX_W'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dff_load_arbiter.sv
// +----------------------------------------------------------------------+
// | dff_load_arbiter : round-robin load scheduler for a shared register  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dff_load_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic               clk,
  input  logic               rstn,
  dff_load_arbiter_if.slave  bus
);

  localparam int                   IDX_W      = clog2(NREQ);
  localparam logic [IDX_W-1:0]     C_LAST     = IDX_W'(NREQ - 1);
  localparam logic [GAP_CNT_W-1:0] C_GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       r_win;
  logic [IDX_W-1:0]       r_owner;
  logic [IDX_W-1:0]       w_pick_idx;
  logic [IDX_W-1:0]       w_ptr_inc;
  logic                   w_pick_any;
  logic [GAP_CNT_W-1:0]   r_gap_cnt;
  logic [WIDTH-1:0]       r_q;
  logic                   r_q_valid;
  logic [WIDTH-1:0]       w_load_data;
  logic [NREQ-1:0]        w_gnt;
  logic                   w_load_ok;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req (bus.req),
    .ptr (r_ptr),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  assign w_ptr_inc   = (r_win == C_LAST) ? '0 : r_win + 1'b1;
  assign w_load_data = bus.wr_data[int'(r_win)*WIDTH +: WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    w_load_ok   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_any) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_gnt[r_win] = 1'b1;
        // clr wins over the load; a dropped req aborts the grant
        w_load_ok    = !bus.clr && bus.req[r_win];
        w_state_nxt  = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (r_gap_cnt == C_GAP_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_pick_any) r_win <= w_pick_idx;
      if (r_state == S_LOAD) begin
        r_gap_cnt <= '0;
        if (bus.clr || bus.req[r_win]) r_ptr <= w_ptr_inc;
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_owner   <= '0;
    end else if (bus.clr) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else if (w_load_ok) begin
      r_q       <= w_load_data;
      r_q_valid <= 1'b1;
      r_owner   <= r_win;
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.owner   = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_dff_load_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_dff_load_arbiter : vector table, corner sequences, random vs model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dff_load_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int GAP   = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  dff_load_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  dff_load_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(GAP)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  req;
    logic [31:0] data;
    logic        clr;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        v;
    logic [1:0]  own;
  } vec_t;

  vec_t tbl [22];

  // Reference: phase 0 idle, 1 granted to m_w, 2 waiting m_left gap cycles
  int         m_phase, m_w, m_ptr, m_left, m_own;
  logic [7:0] m_q;
  logic       m_v;

  task automatic model_reset();
    m_phase = 0; m_w = 0; m_ptr = 0; m_left = 0; m_own = 0; m_q = 8'h00; m_v = 1'b0;
  endtask

  task automatic model_step();
    int ph, w, p, lf, ow;
    logic [7:0]  nq;
    logic        nv;
    logic [31:0] d;
    ph = m_phase; w = m_w; p = m_ptr; lf = m_left; ow = m_own; nq = m_q; nv = m_v;
    d = bus.wr_data;
    if (bus.clr) begin nq = 8'h00; nv = 1'b0; end
    if (m_phase == 0) begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (bus.req[(m_ptr + k) % NREQ]) begin w = (m_ptr + k) % NREQ; ph = 1; end
    end else if (m_phase == 1) begin
      if (bus.clr) p = (m_w + 1) % NREQ;
      else if (bus.req[m_w]) begin
        nq = d[m_w*8 +: 8]; nv = 1'b1; ow = m_w; p = (m_w + 1) % NREQ;
      end
      if (GAP > 0) begin ph = 2; lf = GAP; end else ph = 0;
    end else begin
      lf = m_left - 1;
      if (lf == 0) ph = 0;
    end
    m_phase = ph; m_w = w; m_ptr = p; m_left = lf; m_own = ow; m_q = nq; m_v = nv;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic [3:0] eg;
    eg = (m_phase == 1) ? (4'b0001 << m_w) : 4'b0000;
    chk("model_gnt",   32'(bus.gnt),     32'(eg));
    chk("model_q",     32'(bus.q),       32'(m_q));
    chk("model_valid", 32'(bus.q_valid), 32'(m_v));
    chk("model_owner", 32'(bus.owner),   32'(m_own));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt",   32'(bus.gnt),     32'h0);
    chk("rst_q",     32'(bus.q),       32'h0);
    chk("rst_valid", 32'(bus.q_valid), 32'h0);
    chk("rst_owner", 32'(bus.owner),   32'h0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0; bus.wr_data = '0; bus.clr = 1'b0;
    //           req      data          clr   gnt      q      v     own
    tbl[0]  = '{4'b0100, 32'h00A50000, 1'b0, 4'b0100, 8'h00, 1'b0, 2'd0};
    tbl[1]  = '{4'b0100, 32'h00A50000, 1'b0, 4'b0000, 8'hA5, 1'b1, 2'd2};
    tbl[2]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'hA5, 1'b1, 2'd2};
    tbl[3]  = '{4'b1000, 32'h5A000000, 1'b0, 4'b1000, 8'hA5, 1'b1, 2'd2};
    tbl[4]  = '{4'b1000, 32'h5A000000, 1'b0, 4'b0000, 8'h5A, 1'b1, 2'd3};
    tbl[5]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h5A, 1'b1, 2'd3};
    tbl[6]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 8'h00, 1'b0, 2'd3};
    tbl[7]  = '{4'b0001, 32'h00000077, 1'b0, 4'b0001, 8'h00, 1'b0, 2'd3};
    tbl[8]  = '{4'b0001, 32'h00000077, 1'b0, 4'b0000, 8'h77, 1'b1, 2'd0};
    tbl[9]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h77, 1'b1, 2'd0};
    tbl[10] = '{4'b0010, 32'h00003300, 1'b0, 4'b0010, 8'h77, 1'b1, 2'd0};
    tbl[11] = '{4'b0000, 32'h00003300, 1'b0, 4'b0000, 8'h77, 1'b1, 2'd0};
    tbl[12] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h77, 1'b1, 2'd0};
    tbl[13] = '{4'b0011, 32'h00003322, 1'b0, 4'b0010, 8'h77, 1'b1, 2'd0};
    tbl[14] = '{4'b0011, 32'h00003322, 1'b0, 4'b0000, 8'h33, 1'b1, 2'd1};
    tbl[15] = '{4'b1000, 32'hFF000000, 1'b0, 4'b0000, 8'h33, 1'b1, 2'd1};
    tbl[16] = '{4'b1000, 32'hFF000000, 1'b0, 4'b1000, 8'h33, 1'b1, 2'd1};
    tbl[17] = '{4'b1000, 32'hFF000000, 1'b1, 4'b0000, 8'h00, 1'b0, 2'd1};
    tbl[18] = '{4'b1001, 32'hFF000011, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd1};
    tbl[19] = '{4'b1001, 32'hFF000011, 1'b0, 4'b0001, 8'h00, 1'b0, 2'd1};
    tbl[20] = '{4'b1001, 32'hFF000011, 1'b0, 4'b0000, 8'h11, 1'b1, 2'd0};
    tbl[21] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h11, 1'b1, 2'd0};

    #12;
    do_reset();

    for (int i = 0; i < 22; i++) begin
      bus.req = tbl[i].req; bus.wr_data = tbl[i].data; bus.clr = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d_gnt", i),   32'(bus.gnt),     32'(tbl[i].gnt));
      chk($sformatf("vec%0d_q", i),     32'(bus.q),       32'(tbl[i].q));
      chk($sformatf("vec%0d_valid", i), 32'(bus.q_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_owner", i), 32'(bus.owner),   32'(tbl[i].own));
    end
    bus.req = '0; bus.clr = 1'b0;
    tick(); tick();

    // Reset asserted while requester 2 holds the grant
    @(negedge clk);
    do_reset();
    bus.req = 4'b0100; bus.wr_data = 32'h00A50000;
    tick();
    chk("midload_gnt", 32'(bus.gnt), 32'h4);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("midload_rst_gnt",   32'(bus.gnt),     32'h0);
    chk("midload_rst_q",     32'(bus.q),       32'h0);
    chk("midload_rst_valid", 32'(bus.q_valid), 32'h0);
    chk("midload_rst_owner", 32'(bus.owner),   32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("midload_regrant", 32'(bus.gnt), 32'h4);
    tick();
    chk("midload_q", 32'(bus.q), 32'hA5);
    bus.req = '0;
    tick(); tick();

    // Full contention from pointer 0
    @(negedge clk);
    do_reset();
    bus.req = 4'b1111; bus.wr_data = 32'h13121110;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (n % 3 == 1) chk($sformatf("cont_gnt_c%0d", n), 32'(bus.gnt), 32'(1 << (((n - 1) / 3) % 4)));
      else            chk($sformatf("cont_gnt_c%0d", n), 32'(bus.gnt), 32'h0);
      if (n % 3 == 2) chk($sformatf("cont_q_c%0d", n), 32'(bus.q), 32'h10 + 32'(((n - 2) / 3) % 4));
    end

    // Random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) bus.wr_data = $urandom;
      bus.clr = ($urandom_range(0, 15) == 0);
      tick();
      if (!$onehot0(bus.gnt)) chk("rand_gnt_onehot", 32'(bus.gnt), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dff_load_arbiter.md
Name: dff_load_arbiter

Overview:
- Shares one WIDTH-bit D-flip-flop holding register between NREQ requesters.
- Arbitration is round-robin. Each requester offers a data word with a req/gnt handshake, and exactly one word is loaded per grant.
- Sits in front of the flip-flop storage primitives as their load scheduler. It also exposes the stored value, a valid flag and the index of the last writer.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, data and register width in bits.
- GAP, 1, idle cycles enforced after each load (0..15).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester load request; bit i belongs to requester i.
- wr_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- clr  input  1  synchronous clear of the stored value.
- gnt  output  NREQ  one-hot grant, high for exactly one cycle per grant.
- q  output  WIDTH  stored register value.
- q_valid  output  1  q holds a loaded value.
- owner  output  clog2(NREQ)  index of the requester whose data is in q.

Behaviour:
- Reset (rstn=0, asynchronous, any state including mid-LOAD):
  - gnt=0, q=0, q_valid=0, owner=0, rr pointer=0, gap counter=0, state=IDLE.
  - An in-flight load is discarded.
- State machine: IDLE, LOAD, GAP.
- IDLE:
  - If any req bit is set, select winner w: the first set bit searching upward from the pointer, modulo NREQ.
  - Next edge: gnt[w]=1, latch w, state=LOAD.
  - If no req, stay in IDLE.
- LOAD (gnt[w] high this cycle). Rules are applied in priority order:
  - clr=1: q=0, q_valid=0, pointer=(w+1)%NREQ. The grant is consumed but nothing is stored.
  - req[w]=0 (abort): q, q_valid, owner and pointer all unchanged.
  - Otherwise: q=wr_data[w] sampled this cycle, q_valid=1, owner=w, pointer=(w+1)%NREQ.
  - In every case gnt=0 at the next edge. State goes to GAP if GAP>0, else IDLE.
- GAP: count GAP cycles with gnt=0 and req ignored, then return to IDLE.
- Latency:
  - req seen in IDLE at cycle 0, gnt at cycle 1, q updated at cycle 2.
  - Under continuous requests, grant period is 2+GAP cycles.
- Requester rule: hold req and wr_data stable until gnt is seen. Dropping req is legal at any time. Requests not selected stay pending; there is no starvation, since each requester is served within NREQ grants.
- clr outside LOAD: q=0, q_valid=0 at the next edge. State, pointer and owner are unchanged.
- Pointer wraps from NREQ-1 to 0.
- owner and q change together; owner never changes without a successful load.
- gnt is never multi-hot and never high outside LOAD.

Decomposition:
- Shared package dff_arb_pkg:
  - state enum {IDLE, LOAD, GAP}.
  - Index-width function clog2.
  - Constant GAP_CNT_W=4.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req, ptr.
  - Outputs: any, idx.
  - Instantiated once.
- All flops (state, pointer, q, q_valid, owner, gap counter) live in the top module. They use the async active-low rstn in their sensitivity list.

Test Plan:
- Reset mid-LOAD: req=0100, wr_data[2]=8'hA5; assert rstn=0 while gnt=0100 -> gnt=0, q=8'h00, q_valid=0, owner=0 immediately. After release, an untouched req[2] is re-granted at cycle 1.
- Single request: req=0100, wr_data[2]=8'hA5 at cycle 0 -> gnt=0100 at cycle 1; q=8'hA5, q_valid=1, owner=2 at cycle 2.
- Full contention, pointer 0, GAP=1: req=1111 held, data i = 8'h10+i -> gnt at cycles 1,4,7,10,13 to requesters 0,1,2,3,0. q sequence 8'h10,11,12,13,10, showing wrap 3->0.
- Abort: req=0010, drop req[1] in the gnt cycle -> q and owner keep their prior values. The next req=0011 grants requester 1 first, since the pointer did not advance.
- Clear priority: clr=1 during LOAD for requester 3 with wr_data[3]=8'hFF -> q=8'h00, q_valid=0. The next grant with req=1001 goes to requester 0.
- clr in IDLE after q=8'h5A: -> q=0, q_valid=0; owner unchanged; the following request is granted normally.
